// File: rtl/sakebi_eth_pkg.sv
// sakebi_eth_pkg
// Shared constants for the Ethernet transmit framer: preamble/SFD bytes,
// field lengths, FSM state encodings and the FCS byte-select helper.
package sakebi_eth_pkg;

    localparam logic [7:0] ETH_PREAMBLE = 8'h55;
    localparam logic [7:0] ETH_SFD      = 8'hD5;
    localparam int         PREAMBLE_LEN = 8;    // includes the SFD byte
    localparam int         FCS_LEN      = 4;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_PAYLOAD  = 3'd2;
    localparam logic [2:0] ST_WAIT_FCS = 3'd3;
    localparam logic [2:0] ST_FCS      = 3'd4;
    localparam logic [2:0] ST_IFG      = 3'd5;

    // Byte idx (0 = first on the wire) of the 32-bit FCS word.
    function automatic logic [7:0] fcs_byte(input logic [31:0] fcs,
                                            input logic [1:0]  idx,
                                            input logic        msb_first);
        logic [1:0]  sel;
        logic [31:0] sh;
        sel = msb_first ? (2'd3 - idx) : idx;
        sh  = fcs >> {sel, 3'b000};
        return sh[7:0];
    endfunction

endpackage

// File: rtl/sakebi_eth_tx_framer_fifo.sv
// sakebi_byte_fifo
// Synchronous FIFO with show-ahead read data (dout is the head entry).
// Push while full and pop while empty are ignored.
// Ports:
//   i_axis_ACLK / i_axis_ARESETn : clock, async active-low reset
//   push, din                    : write strobe and data
//   pop, dout                    : read strobe and head data
//   full, empty, count           : occupancy status
module sakebi_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       i_axis_ACLK,
    input  logic                       i_axis_ARESETn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge i_axis_ACLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/sakebi_eth_tx_framer.sv
// sakebi_eth_tx_framer
// Buffers the payload stream and emits preamble+SFD, payload, 4-byte FCS
// (from the CRC32 wrapper result beat), then holds the inter-frame gap.
// Ports:
//   i_axis_ACLK / i_axis_ARESETn  : clock, async active-low reset
//   i_axis_TVALID/TDATA, o_axis_TREADY : payload in; frame ends on first TVALID low
//   i_crc_TVALID/TDATA            : one-cycle FCS result strobe
//   o_axis_TVALID/TDATA/TLAST     : byte stream out (no backpressure), TLAST on last FCS byte
//   o_frame_err                   : sticky per frame, [0] underrun, [1] FCS late
module sakebi_eth_tx_framer
    import sakebi_eth_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int IFG_LEN       = 12,
    parameter bit FCS_MSB_FIRST = 1'b1
) (
    input  logic        i_axis_ACLK,
    input  logic        i_axis_ARESETn,
    input  logic        i_axis_TVALID,
    output logic        o_axis_TREADY,
    input  logic [7:0]  i_axis_TDATA,
    input  logic        i_crc_TVALID,
    input  logic [31:0] i_crc_TDATA,
    output logic        o_axis_TVALID,
    output logic [7:0]  o_axis_TDATA,
    output logic        o_axis_TLAST,
    output logic [1:0]  o_frame_err
);

    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_MAX = (IFG_LEN > PREAMBLE_LEN) ? IFG_LEN : PREAMBLE_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    logic [2:0]       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             in_open, open_d;
    logic [31:0]      crc_q;
    logic             crc_vld;
    logic             crc_hit, crc_avail, crc_clr;
    logic [31:0]      crc_word;
    logic             in_capture;
    logic             push, pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count, count_d;
    logic             vld_d, last_d, tready_d;
    logic [7:0]       data_d;
    logic [1:0]       err_d;

    sakebi_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .i_axis_ACLK    (i_axis_ACLK),
        .i_axis_ARESETn (i_axis_ARESETn),
        .push           (push),
        .din            (i_axis_TDATA),
        .pop            (pop),
        .dout           (fifo_dout),
        .full           (fifo_full),
        .empty          (fifo_empty),
        .count          (fifo_count)
    );

    assign in_capture = (state == ST_PREAMBLE) || (state == ST_PAYLOAD) || (state == ST_WAIT_FCS);
    assign push       = i_axis_TVALID && o_axis_TREADY && !fifo_full &&
                        ((state == ST_IDLE) || in_capture);
    assign pop        = (state == ST_PAYLOAD) && !fifo_empty;

    // A strobe on the same edge as the empty/exit check counts as latched;
    // the live value is used for the first FCS byte in that case.
    assign crc_hit   = in_capture && i_crc_TVALID;
    assign crc_avail = crc_vld || crc_hit;
    assign crc_word  = crc_hit ? i_crc_TDATA : crc_q;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        open_d  = in_open;
        err_d   = o_frame_err;
        vld_d   = 1'b0;
        data_d  = 8'h00;
        last_d  = 1'b0;
        crc_clr = 1'b0;
        if (in_capture && in_open && !i_axis_TVALID) open_d = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_axis_TVALID) begin
                    state_d = ST_PREAMBLE;
                    cnt_d   = '0;
                    open_d  = 1'b1;
                    err_d   = 2'b00;
                end
            end
            ST_PREAMBLE: begin
                vld_d = 1'b1;
                if (cnt == CNT_W'(PREAMBLE_LEN - 1)) begin
                    data_d  = ETH_SFD;
                    state_d = ST_PAYLOAD;
                    cnt_d   = '0;
                end else begin
                    data_d = ETH_PREAMBLE;
                    cnt_d  = cnt + CNT_W'(1);
                end
            end
            ST_PAYLOAD: begin
                if (!fifo_empty) begin
                    vld_d  = 1'b1;
                    data_d = fifo_dout;
                end else if (in_open) begin
                    err_d[0] = 1'b1;            // source fell behind: bubble on the wire
                end else if (crc_avail) begin
                    // Emit FCS byte 0 now so the FCS follows the payload without a gap.
                    vld_d   = 1'b1;
                    data_d  = fcs_byte(crc_word, 2'd0, FCS_MSB_FIRST);
                    state_d = ST_FCS;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d  = ST_WAIT_FCS;
                    err_d[1] = 1'b1;
                end
            end
            ST_WAIT_FCS: begin
                if (crc_avail) begin
                    state_d = ST_FCS;
                    cnt_d   = '0;
                end
            end
            ST_FCS: begin
                vld_d  = 1'b1;
                data_d = fcs_byte(crc_q, cnt[1:0], FCS_MSB_FIRST);
                if (cnt == CNT_W'(FCS_LEN - 1)) begin
                    last_d  = 1'b1;
                    crc_clr = 1'b1;
                    state_d = ST_IFG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_IFG: begin
                if (cnt == CNT_W'(IFG_LEN - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // TREADY is registered, so it is derived from next-cycle state/occupancy.
    always_comb begin
        count_d  = fifo_count + CW'(push) - CW'(pop);
        tready_d = 1'b0;
        case (state_d)
            ST_IDLE:                              tready_d = 1'b1;
            ST_PREAMBLE, ST_PAYLOAD, ST_WAIT_FCS: tready_d = open_d && (count_d != CW'(FIFO_DEPTH));
            default:                              tready_d = 1'b0;
        endcase
    end

    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            in_open       <= 1'b0;
            o_axis_TVALID <= 1'b0;
            o_axis_TDATA  <= 8'h00;
            o_axis_TLAST  <= 1'b0;
            o_frame_err   <= 2'b00;
            o_axis_TREADY <= 1'b1;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            in_open       <= open_d;
            o_axis_TVALID <= vld_d;
            o_axis_TDATA  <= data_d;
            o_axis_TLAST  <= last_d;
            o_frame_err   <= err_d;
            o_axis_TREADY <= tready_d;
        end
    end

    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            crc_q   <= 32'h0;
            crc_vld <= 1'b0;
        end else if (crc_hit) begin
            crc_q   <= i_crc_TDATA;
            crc_vld <= 1'b1;
        end else if (crc_clr) begin
            crc_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sakebi_eth_tx_framer.sv
// tb_sakebi_eth_tx_framer
// Scoreboard bench: expected bytes are queued when a frame is issued and
// popped by per-DUT monitors. Two DUTs share stimulus: MSB-first and
// LSB-first FCS ordering.
module tb_sakebi_eth_tx_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_axis_TVALID = 1'b0;
    logic [7:0]  i_axis_TDATA = 8'h00;
    logic        i_crc_TVALID = 1'b0;
    logic [31:0] i_crc_TDATA = 32'h0;

    logic        m_tready, m_tvalid, m_tlast;
    logic [7:0]  m_tdata;
    logic [1:0]  m_err;
    logic        l_tready, l_tvalid, l_tlast;
    logic [7:0]  l_tdata;
    logic [1:0]  l_err;

    int checks = 0, failures = 0;
    int cyc = 0, frames_done = 0, start_cyc = 0, tlast_cyc = 0, crc_cyc = 0;
    logic [8:0] exp_m[$];
    logic [8:0] exp_l[$];
    logic in_fr_m = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    sakebi_eth_tx_framer #(.FIFO_DEPTH(16), .IFG_LEN(12), .FCS_MSB_FIRST(1'b1)) dut (
        .i_axis_ACLK(clk), .i_axis_ARESETn(rst_n),
        .i_axis_TVALID(i_axis_TVALID), .o_axis_TREADY(m_tready), .i_axis_TDATA(i_axis_TDATA),
        .i_crc_TVALID(i_crc_TVALID), .i_crc_TDATA(i_crc_TDATA),
        .o_axis_TVALID(m_tvalid), .o_axis_TDATA(m_tdata), .o_axis_TLAST(m_tlast),
        .o_frame_err(m_err));

    sakebi_eth_tx_framer #(.FIFO_DEPTH(16), .IFG_LEN(12), .FCS_MSB_FIRST(1'b0)) dut_lsb (
        .i_axis_ACLK(clk), .i_axis_ARESETn(rst_n),
        .i_axis_TVALID(i_axis_TVALID), .o_axis_TREADY(l_tready), .i_axis_TDATA(i_axis_TDATA),
        .i_crc_TVALID(i_crc_TVALID), .i_crc_TDATA(i_crc_TDATA),
        .o_axis_TVALID(l_tvalid), .o_axis_TDATA(l_tdata), .o_axis_TLAST(l_tlast),
        .o_frame_err(l_err));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: compare every output byte {TLAST, TDATA} against the queue.
    always @(negedge clk) begin
        if (!rst_n) in_fr_m = 1'b0;
        else if (m_tvalid) begin
            if (!in_fr_m) begin start_cyc = cyc; in_fr_m = 1'b1; end
            if (exp_m.size() == 0) begin
                checks++; failures++;
                $display("FAIL msb_unexpected: got %0h, none expected (cycle %0d)", {m_tlast, m_tdata}, cyc);
            end else chk("msb_byte", {23'd0, m_tlast, m_tdata}, {23'd0, exp_m.pop_front()});
            if (m_tlast) begin tlast_cyc = cyc; frames_done++; in_fr_m = 1'b0; end
        end
    end

    always @(negedge clk) begin
        if (rst_n && l_tvalid) begin
            if (exp_l.size() == 0) begin
                checks++; failures++;
                $display("FAIL lsb_unexpected: got %0h, none expected (cycle %0d)", {l_tlast, l_tdata}, cyc);
            end else chk("lsb_byte", {23'd0, l_tlast, l_tdata}, {23'd0, exp_l.pop_front()});
        end
    end

    task automatic expect_frame(input logic [7:0] base, input int n, input logic [31:0] crc, input bit with_fcs);
        for (int i = 0; i < 7; i++) begin exp_m.push_back(9'h055); exp_l.push_back(9'h055); end
        exp_m.push_back(9'h0D5); exp_l.push_back(9'h0D5);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = base + 8'(i);
            exp_m.push_back({1'b0, b}); exp_l.push_back({1'b0, b});
        end
        if (with_fcs) begin
            for (int j = 0; j < 4; j++) begin
                logic [31:0] hi, lo;
                hi = crc >> (8 * (3 - j));
                lo = crc >> (8 * j);
                exp_m.push_back({(j == 3), hi[7:0]});
                exp_l.push_back({(j == 3), lo[7:0]});
            end
        end
    endtask

    task automatic drive_bytes(input logic [7:0] base, input int n, output int waited);
        waited = 0;
        for (int i = 0; i < n; i++) begin
            i_axis_TVALID = 1'b1;
            i_axis_TDATA  = base + 8'(i);
            while (m_tready !== 1'b1 && waited < 500) begin @(negedge clk); waited++; end
            if (waited >= 500) begin
                checks++; failures++;
                $display("FAIL tready_timeout: got 0 expected 1 (cycle %0d)", cyc);
            end
            @(negedge clk);
        end
        i_axis_TVALID = 1'b0;
    endtask

    // Called on the negedge after the last byte edge; strobe lands 'delay' edges later.
    task automatic strobe_crc(input logic [31:0] v, input int delay);
        repeat (delay - 1) @(negedge clk);
        i_crc_TVALID = 1'b1;
        i_crc_TDATA  = v;
        @(negedge clk);
        crc_cyc = cyc;
        i_crc_TVALID = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int g = 0;
        while (frames_done < target && g < 2000) begin @(negedge clk); #1; g++; end
        if (frames_done < target) begin
            checks++; failures++;
            $display("FAIL frame_timeout: got %0d frames expected %0d", frames_done, target);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, t_a;
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_tdata",  {24'd0, m_tdata},  32'd0);
        chk("rst_tlast",  {31'd0, m_tlast},  32'd0);
        chk("rst_err",    {30'd0, m_err},    32'd0);
        chk("rst_tready", {31'd0, m_tready}, 32'd1);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Basic 60-byte frame, CRC six cycles after the last byte
        expect_frame(8'h00, 60, 32'h2639F4CB, 1'b1);
        drive_bytes(8'h00, 60, w);
        strobe_crc(32'h2639F4CB, 6);
        wait_frames(1);
        chk("basic_len_cycles", 32'(tlast_cyc - start_cyc), 32'd71);
        chk("basic_err", {30'd0, m_err}, 32'd0);
        chk("basic_err_lsb", {30'd0, l_err}, 32'd0);

        // Late CRC: 4-byte frame, strobe 20 cycles after the last byte
        expect_frame(8'hC0, 4, 32'h1A2B3C4D, 1'b1);
        drive_bytes(8'hC0, 4, w);
        strobe_crc(32'h1A2B3C4D, 20);
        wait_frames(2);
        chk("late_tlast_after_strobe", 32'(tlast_cyc - crc_cyc), 32'd4);
        chk("late_err", {30'd0, m_err}, 32'd2);

        // Source drops TVALID for one cycle: frame closes, resumed bytes refused
        expect_frame(8'hA0, 10, 32'h0BADF00D, 1'b1);
        drive_bytes(8'hA0, 10, w);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            i_axis_TVALID = 1'b1; i_axis_TDATA = 8'hEE;
            chk("closed_tready", {31'd0, m_tready}, 32'd0);
            @(negedge clk);
        end
        i_axis_TVALID = 1'b0;
        strobe_crc(32'h0BADF00D, 1);
        wait_frames(3);
        chk("drop_err", {30'd0, m_err}, 32'd0);

        // Frame held open while the FIFO drains: underrun
        force dut.in_open = 1'b1;
        force dut_lsb.in_open = 1'b1;
        expect_frame(8'h10, 12, 32'hDEADBEEF, 1'b1);
        drive_bytes(8'h10, 12, w);
        repeat (20) @(negedge clk);
        #1;
        chk("underrun_err_live", {30'd0, m_err}, 32'd1);
        chk("underrun_tvalid", {31'd0, m_tvalid}, 32'd0);
        strobe_crc(32'hDEADBEEF, 1);
        release dut.in_open;
        release dut_lsb.in_open;
        wait_frames(4);
        chk("underrun_err", {30'd0, m_err}, 32'd1);
        chk("underrun_err_lsb", {30'd0, l_err}, 32'd1);

        // Back-to-back: second frame offered during the IFG
        expect_frame(8'h40, 60, 32'h12345678, 1'b1);
        expect_frame(8'h60, 60, 32'hCAFEBABE, 1'b1);
        drive_bytes(8'h40, 60, w);
        strobe_crc(32'h12345678, 6);
        wait_frames(5);
        t_a = tlast_cyc;
        drive_bytes(8'h60, 60, w);
        chk("ifg_tready_low_cycles", 32'(w), 32'd12);
        strobe_crc(32'hCAFEBABE, 6);
        wait_frames(6);
        chk("b2b_start_after_tlast", 32'(start_cyc - t_a), 32'd14);

        // Reset in the middle of the payload
        expect_frame(8'h20, 30, 32'h0, 1'b0);
        drive_bytes(8'h20, 30, w);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_m.delete(); exp_l.delete();
        #1;
        chk("midrst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("midrst_tready", {31'd0, m_tready}, 32'd1);
        chk("midrst_tlast",  {31'd0, m_tlast},  32'd0);
        @(negedge clk); #1;
        chk("midrst_tvalid_clk", {31'd0, m_tvalid}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_tready", {31'd0, m_tready}, 32'd1);
        expect_frame(8'h80, 60, 32'h2639F4CB, 1'b1);
        drive_bytes(8'h80, 60, w);
        strobe_crc(32'h2639F4CB, 6);
        wait_frames(7);
        chk("postrst_len_cycles", 32'(tlast_cyc - start_cyc), 32'd71);
        chk("postrst_err", {30'd0, m_err}, 32'd0);

        repeat (5) @(negedge clk);
        chk("msb_queue_drained", 32'(exp_m.size()), 32'd0);
        chk("lsb_queue_drained", 32'(exp_l.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
